// File: rtl/dino_game_pkg.sv
// Shared types, game constants and renderer register map for the dino sprite sequencer.
package dino_game_pkg;

  typedef enum logic [1:0] {RUN = 2'd0, AIR = 2'd1, DUCK = 2'd2} pose_e;
  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} seq_e;

  localparam logic [7:0] DINO_X       = 8'd100;
  localparam logic [7:0] GROUND_Y     = 8'd100;
  localparam logic [7:0] JUMP_V       = 8'd12;
  localparam logic [7:0] GRAVITY      = 8'd1;
  localparam logic [7:0] SCROLL_SPEED = 8'd3;
  localparam logic [7:0] CACTUS_START = 8'd250;
  localparam logic [7:0] GODZ_X       = 8'd100;
  localparam logic [8:0] GODZ_Y_FULL  = 9'd260;
  localparam logic [7:0] GODZ_Y       = GODZ_Y_FULL[7:0];
  localparam logic [7:0] PARK_X       = 8'd0;
  localparam logic [7:0] PARK_Y       = 8'd0;

  localparam int         NUM_REGS     = 10;
  localparam logic [8:0] REG_DINO_X   = 9'd0;
  localparam logic [8:0] REG_DINO_Y   = 9'd1;
  localparam logic [8:0] REG_JUMP_X   = 9'd2;
  localparam logic [8:0] REG_JUMP_Y   = 9'd3;
  localparam logic [8:0] REG_DUCK_X   = 9'd4;
  localparam logic [8:0] REG_DUCK_Y   = 9'd5;
  localparam logic [8:0] REG_CACTUS_X = 9'd6;
  localparam logic [8:0] REG_CACTUS_Y = 9'd7;
  localparam logic [8:0] REG_GODZ_X   = 9'd8;
  localparam logic [8:0] REG_GODZ_Y   = 9'd9;
  localparam logic [8:0] REG_LAST     = 9'(NUM_REGS - 1);

  // Only the sprite pair matching the current pose is placed; the others are parked.
  function automatic logic [7:0] reg_value(input logic [8:0] addr, input pose_e pose,
                                           input logic [7:0] dino_y, input logic [7:0] cac_x);
    logic [7:0] v;
    v = 8'd0;
    case (addr)
      REG_DINO_X:   v = (pose == RUN)  ? DINO_X : PARK_X;
      REG_DINO_Y:   v = (pose == RUN)  ? dino_y : PARK_Y;
      REG_JUMP_X:   v = (pose == AIR)  ? DINO_X : PARK_X;
      REG_JUMP_Y:   v = (pose == AIR)  ? dino_y : PARK_Y;
      REG_DUCK_X:   v = (pose == DUCK) ? DINO_X : PARK_X;
      REG_DUCK_Y:   v = (pose == DUCK) ? dino_y : PARK_Y;
      REG_CACTUS_X: v = cac_x;
      REG_CACTUS_Y: v = GROUND_Y;
      REG_GODZ_X:   v = GODZ_X;
      REG_GODZ_Y:   v = GODZ_Y;
      default:      v = 8'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/dino_physics_core.sv
// Per-frame dino pose/jump physics and cactus scroll; one step per step_i pulse.
// Optional collision latch enabled by defining COLLISION_DETECT_EN.
module dino_physics_core
  import dino_game_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       step_i,
  input  logic       jump_btn_i,
  input  logic       duck_btn_i,
  output pose_e      pose_o,
  output logic [7:0] dino_y_o,
  output logic [7:0] cac_x_o,
  output logic       game_over_o
);

  pose_e      pose_q, pose_d;
  logic [7:0] vel_q, vel_d;
  logic [7:0] y_q, y_d;
  logic [7:0] cac_q, cac_d;
  logic [9:0] y_sum_s;
  logic       frozen_s;
  logic       step_s;

  assign step_s = step_i && !frozen_s;

  // Velocity is two's complement; y is summed in 10 bits so overshoot in either direction is visible.
  always_comb begin
    pose_d  = pose_q;
    vel_d   = vel_q;
    y_d     = y_q;
    cac_d   = cac_q;
    y_sum_s = {2'b00, y_q} + {{2{vel_q[7]}}, vel_q};
    if (step_s) begin
      case (pose_q)
        RUN: begin
          if (jump_btn_i) begin
            pose_d = AIR;
            vel_d  = 8'd0 - JUMP_V;
          end else if (duck_btn_i) begin
            pose_d = DUCK;
          end else begin
            pose_d = RUN;
          end
        end
        DUCK: begin
          if (jump_btn_i) begin
            pose_d = AIR;
            vel_d  = 8'd0 - JUMP_V;
          end else if (!duck_btn_i) begin
            pose_d = RUN;
          end else begin
            pose_d = DUCK;
          end
        end
        AIR: begin
          vel_d = vel_q + GRAVITY;
          if (y_sum_s[9]) begin
            y_d = 8'd0;
          end else if (y_sum_s >= {2'b00, GROUND_Y}) begin
            y_d    = GROUND_Y;
            vel_d  = 8'd0;
            pose_d = RUN;
          end else begin
            y_d = y_sum_s[7:0];
          end
        end
        default: pose_d = RUN;
      endcase
      if (cac_q < SCROLL_SPEED) begin
        cac_d = CACTUS_START;
      end else begin
        cac_d = cac_q - SCROLL_SPEED;
      end
    end else begin
      pose_d = pose_q;
    end
  end

`ifdef COLLISION_DETECT_EN
  logic       game_over_q, game_over_d;
  logic [8:0] cac_ext_s;

  assign cac_ext_s   = {1'b0, cac_d};
  assign frozen_s    = game_over_q;
  assign game_over_o = game_over_q;

  // Hit test uses the post-step position and pose.
  always_comb begin
    if (step_s && (cac_ext_s < ({1'b0, DINO_X} + 9'd24)) &&
        ((cac_ext_s + 9'd24) > {1'b0, DINO_X}) && (pose_d != AIR)) begin
      game_over_d = 1'b1;
    end else begin
      game_over_d = game_over_q;
    end
  end
`else
  assign frozen_s    = 1'b0;
  assign game_over_o = 1'b0;
`endif

  // Physics state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pose_q <= RUN;
      vel_q  <= 8'd0;
      y_q    <= GROUND_Y;
      cac_q  <= CACTUS_START;
`ifdef COLLISION_DETECT_EN
      game_over_q <= 1'b0;
`endif
    end else begin
      pose_q <= pose_d;
      vel_q  <= vel_d;
      y_q    <= y_d;
      cac_q  <= cac_d;
`ifdef COLLISION_DETECT_EN
      game_over_q <= game_over_d;
`endif
    end
  end

  assign pose_o   = pose_q;
  assign dino_y_o = y_q;
  assign cac_x_o  = cac_q;

endmodule

// File: rtl/dino_sprite_sequencer.sv
// Frame-rate game stepper that bursts the 10 sprite registers to the renderer each vblank.
// Define COLLISION_DETECT_EN to enable the cactus collision / game_over latch.
module dino_sprite_sequencer
  import dino_game_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        jump_btn,
  input  logic        duck_btn,
  output logic        chipselect,
  output logic        write,
  output logic [8:0]  address,
  output logic [31:0] writedata,
  output logic        busy,
  output logic        overrun,
  output logic        game_over
);

  seq_e       seq_q;
  logic [8:0] addr_q;
  logic       cs_q;
  logic       overrun_q;
  logic       step_s;
  pose_e      pose_s;
  logic [7:0] dino_y_s;
  logic [7:0] cac_x_s;

  assign step_s = frame_tick && (seq_q == IDLE);

  dino_physics_core u_physics (
    .clk         (clk),
    .reset       (reset),
    .step_i      (step_s),
    .jump_btn_i  (jump_btn),
    .duck_btn_i  (duck_btn),
    .pose_o      (pose_s),
    .dino_y_o    (dino_y_s),
    .cac_x_o     (cac_x_s),
    .game_over_o (game_over)
  );

  // Burst sequencer: addresses 0..9 on consecutive cycles after the stepping tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      seq_q     <= IDLE;
      addr_q    <= 9'd0;
      cs_q      <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      case (seq_q)
        IDLE: begin
          if (frame_tick) begin
            seq_q  <= WRITE;
            addr_q <= REG_DINO_X;
            cs_q   <= 1'b1;
          end else begin
            seq_q  <= IDLE;
            addr_q <= 9'd0;
            cs_q   <= 1'b0;
          end
        end
        WRITE: begin
          if (frame_tick) begin
            overrun_q <= 1'b1;
          end else begin
            overrun_q <= overrun_q;
          end
          if (addr_q == REG_LAST) begin
            seq_q  <= IDLE;
            addr_q <= 9'd0;
            cs_q   <= 1'b0;
          end else begin
            addr_q <= addr_q + 9'd1;
          end
        end
        default: begin
          seq_q  <= IDLE;
          addr_q <= 9'd0;
          cs_q   <= 1'b0;
        end
      endcase
    end
  end

  // Data is decoded from registered physics state and gated so the bus is quiet when idle.
  assign writedata  = cs_q ? {24'd0, reg_value(addr_q, pose_s, dino_y_s, cac_x_s)} : 32'd0;
  assign chipselect = cs_q;
  assign write      = cs_q;
  assign busy       = cs_q;
  assign address    = addr_q;
  assign overrun    = overrun_q;

endmodule
